// File: rtl/interface_24in_256out.sv
// Packs a 24-bit pixel stream into 256-bit DDR3 write words with 32 byte-valid flags.
// The first byte lands in data[255:248], and its flag is byte_valid[31].
module interface_24in_256out #(
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clock,
  input  logic                 rst_n,
  input  logic [23:0]          pix_data,
  input  logic                 pix_valid,
  input  logic                 pix_last,
  output logic                 pix_ready,
  output logic [287:0]         wr_data,
  output logic                 wr_data_valid,
  input  logic                 wr_ready_in,
  output logic                 wr_last,
  output logic [CNT_WIDTH-1:0] wr_word_cnt
);

  typedef enum logic [0:0] {StAcc, StFlush} state_e;

  state_e                 state_q, state_d;
  logic [4:0]             cnt_q, cnt_d;
  logic [255:0]           asm_data_q, asm_data_d;
  logic [31:0]            asm_bv_q, asm_bv_d;
  logic [255:0]           out_data_q, out_data_d;
  logic [31:0]            out_bv_q, out_bv_d;
  logic                   out_valid_q, out_valid_d;
  logic                   out_last_q, out_last_d;
  logic [CNT_WIDTH-1:0]   word_cnt_q, word_cnt_d;
  logic                   frame_done_q, frame_done_d;

  logic [5:0]   sum;
  logic         complete;
  logic [4:0]   cnt_next;
  logic [5:0]   pos [3];
  logic [255:0] merged_data, spill_data;
  logic [31:0]  merged_bv, spill_bv;
  logic         out_free, xfer, accept, frame_done;
  logic         load, load_last;
  logic [255:0] load_data;
  logic [31:0]  load_bv;

  // cnt+3 never exceeds 34, so bit 5 flags completion and the low bits are the spill count.
  assign sum      = {1'b0, cnt_q} + 6'd3;
  assign complete = sum[5];
  assign cnt_next = sum[4:0];

  assign out_free  = ~out_valid_q | wr_ready_in;
  assign xfer      = out_valid_q & wr_ready_in;
  assign pix_ready = (state_q == StAcc) & rst_n & (out_free | ~complete);
  assign accept    = pix_valid & pix_ready;
  assign frame_done = frame_done_q | (xfer & out_last_q);

  always_comb begin
    merged_data = asm_data_q;
    merged_bv   = asm_bv_q;
    spill_data  = '0;
    spill_bv    = '0;
    for (int i = 0; i < 3; i++) begin
      pos[i] = {1'b0, cnt_q} + 6'(i);
    end
    for (int j = 0; j < 32; j++) begin
      for (int i = 0; i < 3; i++) begin
        if (pos[i] == 6'(j)) begin
          merged_data[255-8*j -: 8] = pix_data[23-8*i -: 8];
          merged_bv[31-j]           = 1'b1;
        end
        if (pos[i] == 6'(j + 32)) begin
          spill_data[255-8*j -: 8] = pix_data[23-8*i -: 8];
          spill_bv[31-j]           = 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    asm_data_d   = asm_data_q;
    asm_bv_d     = asm_bv_q;
    out_data_d   = out_data_q;
    out_bv_d     = out_bv_q;
    out_valid_d  = out_valid_q & ~xfer;
    out_last_d   = out_last_q;
    word_cnt_d   = word_cnt_q;
    frame_done_d = frame_done;
    load         = 1'b0;
    load_last    = 1'b0;
    load_data    = merged_data;
    load_bv      = merged_bv;

    unique case (state_q)
      StAcc: begin
        if (accept) begin
          if (complete) begin
            load       = 1'b1;
            load_bv    = '1;
            load_last  = pix_last & (cnt_next == 5'd0);
            asm_data_d = spill_data;
            asm_bv_d   = spill_bv;
            cnt_d      = cnt_next;
            if (pix_last && cnt_next != 5'd0) state_d = StFlush;
          end else if (pix_last && out_free) begin
            load       = 1'b1;
            load_last  = 1'b1;
            asm_data_d = '0;
            asm_bv_d   = '0;
            cnt_d      = 5'd0;
          end else begin
            asm_data_d = merged_data;
            asm_bv_d   = merged_bv;
            cnt_d      = cnt_next;
            // Output still busy: park the partial word until it can be flushed.
            if (pix_last) state_d = StFlush;
          end
        end
      end
      StFlush: begin
        if (out_free) begin
          load       = 1'b1;
          load_last  = 1'b1;
          load_data  = asm_data_q;
          load_bv    = asm_bv_q;
          asm_data_d = '0;
          asm_bv_d   = '0;
          cnt_d      = 5'd0;
          state_d    = StAcc;
        end
      end
      default: state_d = StAcc;
    endcase

    if (load) begin
      out_data_d   = load_data;
      out_bv_d     = load_bv;
      out_last_d   = load_last;
      out_valid_d  = 1'b1;
      word_cnt_d   = (frame_done ? '0 : word_cnt_q) + CNT_WIDTH'(1);
      frame_done_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      state_q      <= StAcc;
      cnt_q        <= '0;
      asm_data_q   <= '0;
      asm_bv_q     <= '0;
      out_data_q   <= '0;
      out_bv_q     <= '0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      word_cnt_q   <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      asm_data_q   <= asm_data_d;
      asm_bv_q     <= asm_bv_d;
      out_data_q   <= out_data_d;
      out_bv_q     <= out_bv_d;
      out_valid_q  <= out_valid_d;
      out_last_q   <= out_last_d;
      word_cnt_q   <= word_cnt_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign wr_data       = {out_data_q, out_bv_q};
  assign wr_data_valid = out_valid_q;
  assign wr_last       = out_last_q;
  assign wr_word_cnt   = word_cnt_q;

endmodule

// File: tb/tb_interface_24in_256out.sv
// Bench for interface_24in_256out: a byte-queue reference model plus directed and random traffic.
module tb_interface_24in_256out;

  logic         clock = 1'b0;
  logic         rst_n = 1'b0;
  logic [23:0]  pix_data = '0;
  logic         pix_valid = 1'b0;
  logic         pix_last = 1'b0;
  logic         pix_ready;
  logic [287:0] wr_data;
  logic         wr_data_valid;
  logic         wr_ready_in = 1'b1;
  logic         wr_last;
  logic [15:0]  wr_word_cnt;

  interface_24in_256out #(.CNT_WIDTH(16)) dut (
    .clock        (clock),
    .rst_n        (rst_n),
    .pix_data     (pix_data),
    .pix_valid    (pix_valid),
    .pix_last     (pix_last),
    .pix_ready    (pix_ready),
    .wr_data      (wr_data),
    .wr_data_valid(wr_data_valid),
    .wr_ready_in  (wr_ready_in),
    .wr_last      (wr_last),
    .wr_word_cnt  (wr_word_cnt)
  );

  always #2 clock = ~clock;

  typedef struct {
    logic [255:0] d;
    logic [31:0]  bv;
    logic         last;
    logic [15:0]  cnt;
  } word_t;

  logic [7:0]   cur [$];
  word_t        exp_q [$];
  logic [15:0]  fw = '0;
  int           n_tests = 0;
  int           n_fail = 0;
  int           n_words = 0;
  int           ready_mode = 0;
  int           hold_cnt = 0;
  bit           saw_stall = 0;
  bit           hold_q = 0;
  logic [287:0] held_data = '0;

  task automatic check(input string tag, input logic [287:0] got, input logic [287:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic emit(input int n, input logic lst);
    word_t w;
    w.d  = '0;
    w.bv = '0;
    for (int k = 0; k < n; k++) begin
      w.d[255-8*k -: 8] = cur.pop_front();
      w.bv[31-k] = 1'b1;
    end
    fw++;
    w.cnt  = fw;
    w.last = lst;
    exp_q.push_back(w);
    if (lst) fw = '0;
  endtask

  task automatic model_accept(input logic [23:0] px, input logic lst);
    cur.push_back(px[23:16]);
    cur.push_back(px[15:8]);
    cur.push_back(px[7:0]);
    while (cur.size() >= 32) emit(32, lst && cur.size() == 32);
    if (lst && cur.size() > 0) emit(cur.size(), 1'b1);
  endtask

  // Monitor: score transfers, track accepts into the model, check output hold under backpressure.
  always @(negedge clock) begin
    if (!rst_n) begin
      cur.delete();
      exp_q.delete();
      fw = '0;
      hold_q = 0;
    end else begin
      if (hold_q) check("hold_stable", wr_data, held_data);
      if (wr_data_valid && wr_ready_in) begin
        n_words++;
        if (exp_q.size() == 0) begin
          check("extra_word", 1, 0);
        end else begin
          word_t w;
          w = exp_q.pop_front();
          check("word_data", wr_data, {w.d, w.bv});
          check("word_last", wr_last, w.last);
          check("word_cnt", wr_word_cnt, w.cnt);
        end
      end
      if (pix_valid && !pix_ready) saw_stall = 1;
      if (pix_valid && pix_ready) model_accept(pix_data, pix_last);
      hold_q = wr_data_valid && !wr_ready_in;
      held_data = wr_data;
    end
  end

  always @(posedge clock) begin
    #1;
    if (ready_mode == 0) wr_ready_in = 1'b1;
    else if (ready_mode == 1) wr_ready_in = ($urandom_range(0, 3) != 0);
    else if (hold_cnt > 0) begin
      hold_cnt--;
      wr_ready_in = 1'b0;
    end else wr_ready_in = 1'b1;
  end

  task automatic do_reset();
    @(posedge clock); #1;
    rst_n = 1'b0;
    pix_valid = 1'b0;
    pix_last = 1'b0;
    @(posedge clock);
    @(negedge clock);
    check("rst_valid", wr_data_valid, 0);
    check("rst_data", wr_data, 0);
    check("rst_last", wr_last, 0);
    check("rst_cnt", wr_word_cnt, 0);
    check("rst_ready", pix_ready, 0);
    @(posedge clock); #1;
    rst_n = 1'b1;
  endtask

  task automatic send(input logic [23:0] d, input logic l);
    bit acc;
    acc = 0;
    pix_data = d;
    pix_last = l;
    pix_valid = 1'b1;
    for (int t = 0; t < 300 && !acc; t++) begin
      @(negedge clock);
      acc = pix_ready;
      @(posedge clock); #1;
    end
    if (!acc) check("send_timeout", 0, 1);
    pix_valid = 1'b0;
    pix_last = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 300 && (exp_q.size() != 0 || wr_data_valid); t++) @(negedge clock);
    check("drain_empty", exp_q.size(), 0);
    check("drain_idle", wr_data_valid, 0);
  endtask

  initial begin
    logic [255:0] e1;
    int w0;

    // 1: eleven pixels make one full word, one byte left over
    do_reset();
    for (int k = 1; k <= 11; k++) send(24'(k), 1'b0);
    @(negedge clock);
    e1 = '0;
    for (int k = 1; k <= 10; k++) e1[255-24*(k-1) -: 24] = 24'(k);
    check("t1_valid", wr_data_valid, 1);
    check("t1_data", wr_data, {e1, 32'hFFFF_FFFF});
    check("t1_last", wr_last, 0);
    drain();

    // 2: 32 pixels with last -> exactly three full words
    do_reset();
    w0 = n_words;
    for (int k = 0; k < 32; k++) send(24'($urandom), k == 31);
    drain();
    check("t2_words", n_words - w0, 3);

    // 3: single pixel frame
    do_reset();
    send(24'hAABBCC, 1'b1);
    @(negedge clock);
    check("t3_data", wr_data, {24'hAABBCC, 232'h0, 32'hE000_0000});
    check("t3_last", wr_last, 1);
    check("t3_cnt", wr_word_cnt, 1);
    drain();

    // 4: completing pixel with spill and last -> FLUSH
    do_reset();
    for (int k = 0; k < 10; k++) send(24'($urandom), 1'b0);
    send(24'h112233, 1'b1);
    @(negedge clock);
    check("t4_ready_flush", pix_ready, 0);
    check("t4_w1_tail", wr_data[47:32], 16'h1122);
    check("t4_w1_last", wr_last, 0);
    @(posedge clock);
    @(negedge clock);
    check("t4_w2_byte", wr_data[287:280], 8'h33);
    check("t4_w2_bv", wr_data[31:0], 32'h8000_0000);
    check("t4_w2_last", wr_last, 1);
    drain();

    // 5: backpressure with 40 pixels offered back to back
    do_reset();
    saw_stall = 0;
    w0 = n_words;
    hold_cnt = 60;
    ready_mode = 2;
    for (int k = 0; k < 40; k++) send(24'($urandom), k == 39);
    drain();
    check("t5_stall", saw_stall, 1);
    check("t5_words", n_words - w0, 4);
    ready_mode = 0;

    // 6: reset in mid-frame discards old bytes
    do_reset();
    for (int k = 0; k < 5; k++) send(24'hEEEEEE, 1'b0);
    do_reset();
    for (int k = 1; k <= 11; k++) send(24'(k), 1'b0);
    @(negedge clock);
    check("t6_data", wr_data, {e1, 32'hFFFF_FFFF});
    drain();

    // Random traffic with random backpressure and gaps
    do_reset();
    ready_mode = 1;
    for (int k = 0; k < 400; k++) begin
      send(24'($urandom), ($urandom_range(0, 11) == 0) || k == 399);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clock); #1;
      end
    end
    drain();
    ready_mode = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
